// File: rtl/idma_reg32_3d_driver.sv
`default_nettype none
// ============================================================================
// Module   : idma_reg32_3d_driver
// Brief    : Register-interface initiator that programs and launches one
//            idma_reg32_3d front-end job, optionally waiting for completion.
// Revision : 1.0
// ============================================================================

package idma_reg32_3d_reg_pkg;
    localparam logic [31:0] IDMA_REG32_3D_CONF_OFFSET         = 32'h0000_0000;
    localparam logic [31:0] IDMA_REG32_3D_NEXT_ID_0_OFFSET    = 32'h0000_0044;
    localparam logic [31:0] IDMA_REG32_3D_DONE_ID_0_OFFSET    = 32'h0000_0084;
    localparam logic [31:0] IDMA_REG32_3D_DST_ADDR_OFFSET     = 32'h0000_00C4;
    localparam logic [31:0] IDMA_REG32_3D_SRC_ADDR_OFFSET     = 32'h0000_00C8;
    localparam logic [31:0] IDMA_REG32_3D_LENGTH_OFFSET       = 32'h0000_00CC;
    localparam logic [31:0] IDMA_REG32_3D_DST_STRIDE_2_OFFSET = 32'h0000_00D0;
    localparam logic [31:0] IDMA_REG32_3D_SRC_STRIDE_2_OFFSET = 32'h0000_00D4;
    localparam logic [31:0] IDMA_REG32_3D_REPS_2_OFFSET       = 32'h0000_00D8;
    localparam logic [31:0] IDMA_REG32_3D_DST_STRIDE_3_OFFSET = 32'h0000_00DC;
    localparam logic [31:0] IDMA_REG32_3D_SRC_STRIDE_3_OFFSET = 32'h0000_00E0;
    localparam logic [31:0] IDMA_REG32_3D_REPS_3_OFFSET       = 32'h0000_00E4;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module idma_reg32_3d_driver #(
    parameter int unsigned NumStreams = 1,
    parameter bit          WaitDone   = 1'b0,
    parameter type         reg_req_t  = idma_reg32_3d_reg_pkg::reg_req_t,
    parameter type         reg_rsp_t  = idma_reg32_3d_reg_pkg::reg_rsp_t
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        desc_valid_i,
    output logic        desc_ready_o,
    input  logic [31:0] conf_i,
    input  logic [31:0] src_addr_i,
    input  logic [31:0] dst_addr_i,
    input  logic [31:0] length_i,
    input  logic [31:0] src_str2_i,
    input  logic [31:0] dst_str2_i,
    input  logic [31:0] reps2_i,
    input  logic [31:0] src_str3_i,
    input  logic [31:0] dst_str3_i,
    input  logic [31:0] reps3_i,
    input  logic [3:0]  stream_i,
    output reg_req_t    reg_req_o,
    input  reg_rsp_t    reg_rsp_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_POLL   = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic              gap_q, gap_d;
    logic [3:0]        idx_q, idx_d;
    logic [3:0]        stream_q, stream_d;
    logic [31:0]       id_q, id_d;
    logic              err_q, err_d;
    logic [9:0][31:0]  words_q, words_d;

    logic        req_valid;
    logic        hs;
    logic [31:0] stream_off;

    // Word k of words_q is the k-th register written.
    function automatic logic [31:0] write_addr(input logic [3:0] idx);
        case (idx)
            4'd1:    write_addr = idma_reg32_3d_reg_pkg::IDMA_REG32_3D_SRC_ADDR_OFFSET;
            4'd2:    write_addr = idma_reg32_3d_reg_pkg::IDMA_REG32_3D_DST_ADDR_OFFSET;
            4'd3:    write_addr = idma_reg32_3d_reg_pkg::IDMA_REG32_3D_LENGTH_OFFSET;
            4'd4:    write_addr = idma_reg32_3d_reg_pkg::IDMA_REG32_3D_DST_STRIDE_2_OFFSET;
            4'd5:    write_addr = idma_reg32_3d_reg_pkg::IDMA_REG32_3D_SRC_STRIDE_2_OFFSET;
            4'd6:    write_addr = idma_reg32_3d_reg_pkg::IDMA_REG32_3D_REPS_2_OFFSET;
            4'd7:    write_addr = idma_reg32_3d_reg_pkg::IDMA_REG32_3D_DST_STRIDE_3_OFFSET;
            4'd8:    write_addr = idma_reg32_3d_reg_pkg::IDMA_REG32_3D_SRC_STRIDE_3_OFFSET;
            4'd9:    write_addr = idma_reg32_3d_reg_pkg::IDMA_REG32_3D_REPS_3_OFFSET;
            default: write_addr = idma_reg32_3d_reg_pkg::IDMA_REG32_3D_CONF_OFFSET;
        endcase
    endfunction

    assign stream_off = {26'd0, stream_q, 2'b00};
    // gap_q inserts the idle cycle after every completed access.
    assign req_valid  = ((state_q == ST_WRITE) || (state_q == ST_LAUNCH) || (state_q == ST_POLL))
                        && !gap_q && !rst_i;
    assign hs         = req_valid && reg_rsp_i.ready;

    always_comb begin
        state_d   = state_q;
        gap_d     = 1'b0;
        idx_d     = idx_q;
        stream_d  = stream_q;
        id_d      = id_q;
        err_d     = err_q;
        words_d   = words_q;
        reg_req_o = '0;
        reg_req_o.valid = req_valid;

        case (state_q)
            ST_IDLE: begin
                if (desc_valid_i) begin
                    words_d  = {reps3_i, src_str3_i, dst_str3_i, reps2_i, src_str2_i,
                                dst_str2_i, length_i, dst_addr_i, src_addr_i, conf_i};
                    err_d    = 1'b0;
                    id_d     = '0;
                    idx_d    = '0;
                    stream_d = stream_i;
                    if (32'(stream_i) >= NumStreams) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                reg_req_o.addr  = write_addr(idx_q);
                reg_req_o.write = 1'b1;
                reg_req_o.wdata = words_q[idx_q];
                reg_req_o.wstrb = req_valid ? 4'hF : 4'h0;
                if (hs) begin
                    gap_d = 1'b1;
                    if (reg_rsp_i.error) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (idx_q == 4'd9) begin
                        state_d = ST_LAUNCH;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_LAUNCH: begin
                reg_req_o.addr = idma_reg32_3d_reg_pkg::IDMA_REG32_3D_NEXT_ID_0_OFFSET + stream_off;
                if (hs) begin
                    gap_d = 1'b1;
                    if (reg_rsp_i.error) begin
                        err_d   = 1'b1;
                        id_d    = '0;
                        state_d = ST_RESP;
                    end else begin
                        id_d    = reg_rsp_i.rdata;
                        state_d = WaitDone ? ST_POLL : ST_RESP;
                    end
                end
            end
            ST_POLL: begin
                reg_req_o.addr = idma_reg32_3d_reg_pkg::IDMA_REG32_3D_DONE_ID_0_OFFSET + stream_off;
                if (hs) begin
                    gap_d = 1'b1;
                    if (reg_rsp_i.error) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (reg_rsp_i.rdata == id_q) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (id_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            gap_q    <= 1'b0;
            idx_q    <= '0;
            stream_q <= '0;
            id_q     <= '0;
            err_q    <= 1'b0;
            words_q  <= '0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            idx_q    <= idx_d;
            stream_q <= stream_d;
            id_q     <= id_d;
            err_q    <= err_d;
            words_q  <= words_d;
        end
    end

    assign desc_ready_o = (state_q == ST_IDLE);
    assign id_valid_o   = (state_q == ST_RESP);
    assign id_o         = id_q;
    assign err_o        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_idma_reg32_3d_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_idma_reg32_3d_driver
// Brief    : Directed bench for idma_reg32_3d_driver with a scripted register responder.
// Revision : 1.0
// ============================================================================
module tb_idma_reg32_3d_driver;
    import idma_reg32_3d_reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        dv = 1'b0;
    logic        irdy = 1'b0;
    logic [31:0] fld [10];
    logic [3:0]  stream = 4'd0;

    reg_req_t    req0, req1, req_m;
    reg_rsp_t    rsp0, rsp1, rsp_m;
    logic        dr0, dr1, iv0, iv1, err0, err1;
    logic [31:0] id0, id1;
    logic        dr_m, iv_m, err_m;
    logic [31:0] id_m;

    always #5 clk = ~clk;

    idma_reg32_3d_driver #(.NumStreams(2), .WaitDone(1'b0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .desc_valid_i(dv & ~sel), .desc_ready_o(dr0),
        .conf_i(fld[0]), .src_addr_i(fld[1]), .dst_addr_i(fld[2]), .length_i(fld[3]),
        .src_str2_i(fld[5]), .dst_str2_i(fld[4]), .reps2_i(fld[6]),
        .src_str3_i(fld[8]), .dst_str3_i(fld[7]), .reps3_i(fld[9]),
        .stream_i(stream), .reg_req_o(req0), .reg_rsp_i(rsp0),
        .id_valid_o(iv0), .id_ready_i(irdy & ~sel), .id_o(id0), .err_o(err0)
    );

    idma_reg32_3d_driver #(.NumStreams(4), .WaitDone(1'b1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .desc_valid_i(dv & sel), .desc_ready_o(dr1),
        .conf_i(fld[0]), .src_addr_i(fld[1]), .dst_addr_i(fld[2]), .length_i(fld[3]),
        .src_str2_i(fld[5]), .dst_str2_i(fld[4]), .reps2_i(fld[6]),
        .src_str3_i(fld[8]), .dst_str3_i(fld[7]), .reps3_i(fld[9]),
        .stream_i(stream), .reg_req_o(req1), .reg_rsp_i(rsp1),
        .id_valid_o(iv1), .id_ready_i(irdy & sel), .id_o(id1), .err_o(err1)
    );

    assign req_m = sel ? req1 : req0;
    assign rsp0  = sel ? '0 : rsp_m;
    assign rsp1  = sel ? rsp_m : '0;
    assign dr_m  = sel ? dr1 : dr0;
    assign iv_m  = sel ? iv1 : iv0;
    assign id_m  = sel ? id1 : id0;
    assign err_m = sel ? err1 : err0;

    // Responder: programmable stall per access, error on a chosen access index.
    int          stall_cfg = 0;
    int          err_at = -1;
    int          acc_base = 0;
    logic [31:0] nid = '0;
    logic [31:0] done_seq [8];
    int          stall_q = 0;
    int          n_acc = 0;
    int          poll_i;
    logic [31:0] log_addr  [512];
    logic [31:0] log_wdata [512];
    logic        log_write [512];
    logic [3:0]  log_wstrb [512];
    reg_req_t    s_req, hold_req;
    logic        s_rdy = 1'b0, s_rst = 1'b1, hold_v = 1'b0;
    int          bad_cnt = 0;
    int          stall_seen = 0;

    assign poll_i = n_acc - acc_base - 11;

    always_comb begin
        rsp_m = '0;
        rsp_m.ready = req_m.valid && (stall_q == 0);
        rsp_m.error = rsp_m.ready && ((n_acc - acc_base) == err_at);
        if (req_m.addr >= IDMA_REG32_3D_DONE_ID_0_OFFSET && req_m.addr < IDMA_REG32_3D_DONE_ID_0_OFFSET + 64)
            rsp_m.rdata = done_seq[poll_i[2:0]];
        else if (req_m.addr >= IDMA_REG32_3D_NEXT_ID_0_OFFSET && req_m.addr < IDMA_REG32_3D_NEXT_ID_0_OFFSET + 64)
            rsp_m.rdata = nid;
    end

    always @(negedge clk) begin
        s_req <= req_m;
        s_rdy <= rsp_m.ready;
        s_rst <= rst;
    end

    always @(posedge clk) begin
        if (!s_req.valid) begin
            stall_q <= stall_cfg;
        end else if (!s_rdy) begin
            stall_q    <= stall_q - 1;
            stall_seen <= stall_seen + 1;
        end else begin
            log_addr[n_acc[8:0]]  <= s_req.addr;
            log_wdata[n_acc[8:0]] <= s_req.wdata;
            log_write[n_acc[8:0]] <= s_req.write;
            log_wstrb[n_acc[8:0]] <= s_req.wstrb;
            n_acc   <= n_acc + 1;
            stall_q <= stall_cfg;
        end
        // a stalled request must stay valid and unchanged until accepted
        if (hold_v && !s_rst && (!s_req.valid || s_req != hold_req))
            bad_cnt <= bad_cnt + 1;
        hold_v   <= s_req.valid && !s_rdy && !s_rst;
        hold_req <= s_req;
    end

    int checks = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] fval(input int tag, input int k);
        return {8'hA0, 8'(tag), 8'h00, 8'(k)};
    endfunction

    // Called right after a negedge; returns at the negedge where id_valid is seen.
    task automatic run_job(input int s, input int strm, input int tag, output int cyc);
        irdy = 1'b0;
        sel  = s[0];
        acc_base = n_acc;
        chk("desc_ready_idle", {63'd0, dr_m}, 64'd1);
        for (int k = 0; k < 10; k++) fld[k] = fval(tag, k);
        stream = strm[3:0];
        dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        for (int k = 0; k < 10; k++) fld[k] = 32'hDEAD_0000 | 32'(k);
        stream = 4'hF;
        chk("desc_ready_busy", {63'd0, dr_m}, 64'd0);
        cyc = 1;
        while (!iv_m && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic ack();
        irdy = 1'b1;
        @(negedge clk);
        irdy = 1'b0;
        chk("idle_after_ack", {62'd0, dr_m, iv_m}, 64'h2);
    endtask

    typedef struct {
        int          sel;
        int          strm;
        int          stall;
        int          err_at;
        logic [31:0] nid;
        int          e_nacc;
        logic [31:0] e_id;
        logic        e_err;
        int          e_cyc;
    } vec_t;

    vec_t        vt [6];
    logic [31:0] exp_waddr [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int na;
        int base;
        int iv_seen;

        exp_waddr = '{IDMA_REG32_3D_CONF_OFFSET, IDMA_REG32_3D_SRC_ADDR_OFFSET,
                      IDMA_REG32_3D_DST_ADDR_OFFSET, IDMA_REG32_3D_LENGTH_OFFSET,
                      IDMA_REG32_3D_DST_STRIDE_2_OFFSET, IDMA_REG32_3D_SRC_STRIDE_2_OFFSET,
                      IDMA_REG32_3D_REPS_2_OFFSET, IDMA_REG32_3D_DST_STRIDE_3_OFFSET,
                      IDMA_REG32_3D_SRC_STRIDE_3_OFFSET, IDMA_REG32_3D_REPS_3_OFFSET};
        done_seq = '{32'd3, 32'd3, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int k = 0; k < 10; k++) fld[k] = '0;

        vt[0] = '{sel:0, strm:0, stall:0, err_at:-1, nid:32'h5,    e_nacc:11, e_id:32'h5,    e_err:1'b0, e_cyc:22};
        vt[1] = '{sel:0, strm:1, stall:3, err_at:-1, nid:32'h1234, e_nacc:11, e_id:32'h1234, e_err:1'b0, e_cyc:55};
        vt[2] = '{sel:0, strm:0, stall:0, err_at:3,  nid:32'h6,    e_nacc:4,  e_id:32'h0,    e_err:1'b1, e_cyc:8};
        vt[3] = '{sel:0, strm:2, stall:0, err_at:-1, nid:32'h6,    e_nacc:0,  e_id:32'h0,    e_err:1'b1, e_cyc:1};
        vt[4] = '{sel:0, strm:1, stall:0, err_at:10, nid:32'h9,    e_nacc:11, e_id:32'h0,    e_err:1'b1, e_cyc:22};
        vt[5] = '{sel:1, strm:3, stall:0, err_at:-1, nid:32'h7,    e_nacc:14, e_id:32'h7,    e_err:1'b0, e_cyc:28};

        repeat (3) @(negedge clk);
        chk("rst_state", {56'd0, dr_m, iv_m, err_m, req_m.valid, req_m.wstrb}, {56'd0, 8'b1000_0000});
        chk("rst_id", {32'd0, id_m}, 64'd0);
        chk("rst_dut1", {30'd0, dr1, iv1, id1}, {30'd0, 2'b10, 32'd0});
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            stall_cfg = vt[v].stall;
            err_at    = vt[v].err_at;
            nid       = vt[v].nid;
            run_job(vt[v].sel, vt[v].strm, v + 1, cyc);
            na = n_acc - acc_base;
            chk($sformatf("v%0d_cycles", v), 64'(cyc), 64'(vt[v].e_cyc));
            chk($sformatf("v%0d_id", v), {32'd0, id_m}, {32'd0, vt[v].e_id});
            chk($sformatf("v%0d_err", v), {63'd0, err_m}, {63'd0, vt[v].e_err});
            chk($sformatf("v%0d_naccess", v), 64'(na), 64'(vt[v].e_nacc));
            for (int i = 0; i < na && i < 10; i++) begin
                chk($sformatf("v%0d_w%0d_addr", v, i), {32'd0, log_addr[acc_base + i]}, {32'd0, exp_waddr[i]});
                chk($sformatf("v%0d_w%0d_data", v, i), {32'd0, log_wdata[acc_base + i]}, {32'd0, fval(v + 1, i)});
                chk($sformatf("v%0d_w%0d_ctl", v, i), {59'd0, log_write[acc_base + i], log_wstrb[acc_base + i]}, 64'h1F);
            end
            for (int i = 10; i < na && i < 20; i++) begin
                chk($sformatf("v%0d_r%0d_addr", v, i),
                    {31'd0, log_write[acc_base + i], log_addr[acc_base + i]},
                    {32'd0, ((i == 10) ? IDMA_REG32_3D_NEXT_ID_0_OFFSET : IDMA_REG32_3D_DONE_ID_0_OFFSET)
                            + 32'(4 * vt[v].strm)});
            end
            ack();
        end

        // Result held while id_ready is low, then two jobs back to back.
        stall_cfg = 0; err_at = -1; nid = 32'h22;
        run_job(0, 1, 20, cyc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_resp", {30'd0, iv_m, dr_m, id_m}, {30'd0, 2'b10, 32'h22});
        end
        ack();
        nid = 32'h33;
        run_job(0, 0, 21, cyc);
        chk("b2b_cycles", 64'(cyc), 64'd22);
        chk("b2b_id", {32'd0, id_m}, 64'h33);
        ack();

        // Reset while write 4 is on the bus.
        acc_base = n_acc;
        sel = 1'b0;
        for (int k = 0; k < 10; k++) fld[k] = fval(30, k);
        stream = 4'd0;
        dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        cyc = 0;
        while ((n_acc - acc_base) != 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1;
        chk("w4_on_bus", {31'd0, req_m.valid, req_m.addr}, {31'd0, 1'b1, exp_waddr[4]});
        rst = 1'b1;
        #1;
        chk("rst_drops_valid", {63'd0, req_m.valid}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_w4_state", {24'd0, dr_m, iv_m, err_m, req_m.valid, req_m.wstrb, id_m},
            {24'd0, 8'b1000_0000, 32'd0});
        base = n_acc;
        iv_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (iv_m || req_m.valid) iv_seen++;
        end
        chk("rst_w4_discard", 64'(iv_seen), 64'd0);
        chk("rst_w4_noacc", 64'(n_acc - base), 64'd0);

        // Reset while the response is pending.
        nid = 32'h44;
        run_job(0, 1, 31, cyc);
        chk("resp_pending", {31'd0, iv_m, id_m}, {31'd0, 1'b1, 32'h44});
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_resp_state", {28'd0, dr_m, iv_m, err_m, req_m.valid, id_m}, {28'd0, 4'b1000, 32'd0});
        repeat (5) @(negedge clk);
        chk("rst_resp_noresp", {63'd0, iv_m}, 64'd0);

        chk("stall_exercised", {63'd0, (stall_seen > 0)}, 64'd1);
        chk("req_stable_while_stalled", 64'(bad_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
